// File: rtl/mips_mem_responder.sv
// Memory-side responder for the multi-cycle MIPS core: word RAM plus an MMIO window
// (cycle counter, done/exit code, output FIFO, status). RAM starts zeroed; the program is written over the bus.
module mips_mem_responder #(
    parameter int DEPTH      = 256,
    parameter     INIT_FILE  = "memfile.dat",
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] adr,
    input  logic [31:0] writedata,
    input  logic        memwrite,
    output logic [31:0] readdata,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        done,
    output logic [7:0]  exit_code
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(FIFO_DEPTH);

    localparam logic [15:0] OFF_CYCLES = 16'h0000;
    localparam logic [15:0] OFF_DONE   = 16'h0004;
    localparam logic [15:0] OFF_TXDATA = 16'h0008;
    localparam logic [15:0] OFF_STATUS = 16'h000C;

    localparam logic [FW:0] CNT_FULL = (FW+1)'(FIFO_DEPTH);
    localparam logic [FW-1:0] PTR_ONE = FW'(1);

    // Address decode; the byte-lane bits never matter on this bus
    logic          isMmio;
    logic [15:0]   mmioOff;
    logic [AW-1:0] ramIdx;
    logic          unused_ok;

    assign isMmio    = (adr[31:16] == 16'hFFFF);
    assign mmioOff   = {adr[15:2], 2'b00};
    assign ramIdx    = adr[AW+1:2];
    assign unused_ok = ^adr[1:0];

    logic [31:0] ram_q [DEPTH] = '{default: 32'h0};

    logic [31:0]   cycles_q,   cycles_d;
    logic          done_q,     done_d;
    logic [7:0]    exitCode_q, exitCode_d;
    logic          overflow_q, overflow_d;
    logic [FW-1:0] rdPtr_q,    rdPtr_d;
    logic [FW-1:0] wrPtr_q,    wrPtr_d;
    logic [FW:0]   count_q,    count_d;
    logic [31:0]   fifoMem_q [FIFO_DEPTH];

    // A store presented during reset must have no effect anywhere
    logic storeEn;
    logic ramWe;
    logic txWrite;
    logic doneWrite;
    logic statusWrite;

    assign storeEn     = memwrite && !reset;
    assign ramWe       = storeEn && !isMmio;
    assign txWrite     = storeEn && isMmio && (mmioOff == OFF_TXDATA);
    assign doneWrite   = storeEn && isMmio && (mmioOff == OFF_DONE) && !done_q;
    assign statusWrite = storeEn && isMmio && (mmioOff == OFF_STATUS);

    logic fifoFull;
    logic fifoEmpty;
    logic pop;
    logic push;
    logic overflowSet;

    assign fifoFull    = (count_q == CNT_FULL);
    assign fifoEmpty   = (count_q == '0);
    assign pop         = !fifoEmpty && out_ready;
    assign push        = txWrite && (!fifoFull || pop);
    assign overflowSet = txWrite && fifoFull && !pop;

    always_ff @(posedge clk) begin
        if (ramWe) begin
            ram_q[ramIdx] <= writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= writedata;
        end
    end

    always_comb begin
        cycles_d   = cycles_q;
        done_d     = done_q;
        exitCode_d = exitCode_q;
        overflow_d = overflow_q;
        rdPtr_d    = rdPtr_q;
        wrPtr_d    = wrPtr_q;
        count_d    = count_q;

        if (!done_q) begin
            cycles_d = cycles_q + 32'd1;
        end

        if (doneWrite) begin
            done_d     = 1'b1;
            exitCode_d = writedata[7:0];
        end

        if (pop) begin
            rdPtr_d = rdPtr_q + PTR_ONE;
        end
        if (push) begin
            wrPtr_d = wrPtr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A fresh overflow in the same cycle as a clear request must stay visible
        if (statusWrite && writedata[31]) begin
            overflow_d = 1'b0;
        end
        if (overflowSet) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycles_q   <= 32'h0;
            done_q     <= 1'b0;
            exitCode_q <= 8'h0;
            overflow_q <= 1'b0;
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            count_q    <= '0;
        end else begin
            cycles_q   <= cycles_d;
            done_q     <= done_d;
            exitCode_q <= exitCode_d;
            overflow_q <= overflow_d;
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            count_q    <= count_d;
        end
    end

    // Status only has four bits for the occupancy, so large FIFOs saturate
    logic [31:0] countWide;
    logic [3:0]  countSat;

    assign countWide = 32'(count_q);
    assign countSat  = (countWide > 32'd15) ? 4'hF : countWide[3:0];

    always_comb begin
        readdata = ram_q[ramIdx];
        if (isMmio) begin
            case (mmioOff)
                OFF_CYCLES: readdata = cycles_q;
                OFF_DONE:   readdata = {23'b0, done_q, exitCode_q};
                OFF_STATUS: readdata = {overflow_q, done_q, fifoFull, fifoEmpty, 24'b0, countSat};
                default:    readdata = 32'h0;
            endcase
        end
    end

    assign out_data  = fifoMem_q[rdPtr_q];
    assign out_valid = !fifoEmpty;
    assign done      = done_q;
    assign exit_code = exitCode_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Scoreboard bench for mips_mem_responder: directed scenarios followed by random bus traffic,
// checked against a queue/array reference model of the memory map.
module tb_mips_mem_responder;

    localparam int DEPTH = 256;
    localparam int FD    = 8;

    localparam logic [31:0] A_CYCLES = 32'hFFFF_0000;
    localparam logic [31:0] A_DONE   = 32'hFFFF_0004;
    localparam logic [31:0] A_TX     = 32'hFFFF_0008;
    localparam logic [31:0] A_STATUS = 32'hFFFF_000C;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] adr;
    logic [31:0] writedata;
    logic        memwrite;
    logic [31:0] readdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        done;
    logic [7:0]  exit_code;

    mips_mem_responder #(
        .DEPTH      (DEPTH),
        .INIT_FILE  ("memfile.dat"),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .adr       (adr),
        .writedata (writedata),
        .memwrite  (memwrite),
        .readdata  (readdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done),
        .exit_code (exit_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model of the architectural state
    logic [31:0] ramModel [DEPTH];
    logic [31:0] cyclesM;
    bit          doneM;
    logic [7:0]  exitM;
    bit          ovfM;
    logic [31:0] fifoQ[$];

    // Scoreboard queues consumed by the monitor
    logic [31:0] expQ[$];
    logic [31:0] rdExpQ[$];
    bit          rdPending = 1'b0;
    bit          monEn = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        logic [15:0] off;
        off = {a[15:2], 2'b00};
        if (a[31:16] != 16'hFFFF) return ramModel[a[9:2]];
        case (off)
            16'h0000: return cyclesM;
            16'h0004: return {23'b0, doneM, exitM};
            16'h000C: return {ovfM, doneM, fifoQ.size() == FD, fifoQ.size() == 0, 24'b0, 4'(fifoQ.size())};
            default:  return 32'h0;
        endcase
    endfunction

    // Reference model advances on every rising edge from the inputs presented that cycle
    task automatic modelStep();
        bit          mmio;
        bit          popNow;
        bit          ovfSet;
        bit          ovfClr;
        logic [15:0] off;
        if (reset) begin
            cyclesM = 32'h0;
            doneM   = 1'b0;
            exitM   = 8'h0;
            ovfM    = 1'b0;
            fifoQ.delete();
            expQ.delete();
            return;
        end
        mmio   = (adr[31:16] == 16'hFFFF);
        off    = {adr[15:2], 2'b00};
        popNow = (fifoQ.size() != 0) && out_ready;
        ovfSet = 1'b0;
        ovfClr = 1'b0;
        if (!doneM) cyclesM = cyclesM + 32'd1;
        if (popNow) void'(fifoQ.pop_front());
        if (memwrite) begin
            if (!mmio) begin
                ramModel[adr[9:2]] = writedata;
            end else begin
                case (off)
                    16'h0004: if (!doneM) begin
                        doneM = 1'b1;
                        exitM = writedata[7:0];
                    end
                    16'h0008: if (fifoQ.size() < FD) begin
                        fifoQ.push_back(writedata);
                        expQ.push_back(writedata);
                    end else begin
                        ovfSet = 1'b1;
                    end
                    16'h000C: ovfClr = writedata[31];
                    default: ;
                endcase
            end
        end
        if (ovfSet) ovfM = 1'b1;
        else if (ovfClr) ovfM = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            modelStep();
        end
    end

    // Monitor: samples mid-cycle and pops the scoreboard whenever the DUT presents a response
    initial begin
        forever begin
            @(negedge clk);
            if (monEn) begin
                checkOutput("out_valid", {31'b0, out_valid}, {31'b0, fifoQ.size() != 0});
                checkOutput("done", {31'b0, done}, {31'b0, doneM});
                checkOutput("exit_code", {24'b0, exit_code}, {24'b0, exitM});
                if (out_valid && out_ready) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        $display("[TB] FAIL out_data unexpected pop actual=0x%08h required=none", out_data);
                    end else begin
                        checkOutput("out_data", out_data, expQ.pop_front());
                    end
                end
                if (rdPending) begin
                    if (rdExpQ.size() == 0) begin
                        checks++;
                        $display("[TB] FAIL readdata no expectation actual=0x%08h required=none", readdata);
                    end else begin
                        checkOutput("readdata", readdata, rdExpQ.pop_front());
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic [31:0] a, input logic [31:0] d,
                                 input logic rdy, input logic rd, input logic [31:0] exp);
        memwrite  = we;
        adr       = a;
        writedata = d;
        out_ready = rdy;
        if (rd) rdExpQ.push_back(exp);
        rdPending = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic rdy);
        applyStimulus(1'b1, a, d, rdy, 1'b0, 32'h0);
    endtask

    task automatic rd(input logic [31:0] a, input logic rdy, input logic [31:0] exp);
        applyStimulus(1'b0, a, 32'h0, rdy, 1'b1, exp);
    endtask

    task automatic rdModel(input logic [31:0] a, input logic rdy);
        applyStimulus(1'b0, a, 32'h0, rdy, 1'b1, modelRead(a));
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 32'h0, rdy, 1'b0, 32'h0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic        rdy;
        int          r;

        reset     = 1'b1;
        memwrite  = 1'b0;
        adr       = 32'h0;
        writedata = 32'h0;
        out_ready = 1'b0;
        idle(2, 1'b0);
        reset = 1'b0;
        monEn = 1'b1;

        // Counter after ten idle cycles out of reset
        idle(10, 1'b0);
        rd(A_CYCLES, 1'b0, 32'd10);

        // Give every RAM word a known value
        for (int i = 0; i < DEPTH; i++) wr(32'(i * 4), $urandom, 1'b0);

        // RAM write/read with byte offset and aliasing
        wr(32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        rd(32'h0000_0012, 1'b0, 32'hDEAD_BEEF);
        wr(32'h0000_0410, 32'h1234_5678, 1'b0);
        rd(32'h0000_0010, 1'b0, 32'h1234_5678);

        // Unmapped MMIO
        rd(32'hFFFF_0020, 1'b0, 32'h0);
        wr(32'hFFFF_0020, 32'hFFFF_FFFF, 1'b0);
        rdModel(32'h0000_0020, 1'b0);
        rd(A_STATUS, 1'b0, 32'h1000_0000);
        rd(A_DONE, 1'b0, 32'h0);
        rd(A_TX, 1'b0, 32'h0);

        // Fill, overflow, drain
        for (int i = 1; i <= 8; i++) wr(A_TX, 32'(i), 1'b0);
        rd(A_STATUS, 1'b0, 32'h2000_0008);
        wr(A_TX, 32'd9, 1'b0);
        rd(A_STATUS, 1'b0, 32'hA000_0008);
        idle(8, 1'b1);
        idle(1, 1'b1);
        rd(A_STATUS, 1'b0, 32'h9000_0000);
        wr(A_STATUS, 32'h8000_0000, 1'b0);
        rd(A_STATUS, 1'b0, 32'h1000_0000);

        // Push into a full FIFO while it pops
        for (int i = 0; i < 8; i++) wr(A_TX, 32'h10 + 32'(i), 1'b0);
        wr(A_TX, 32'h99, 1'b1);
        rd(A_STATUS, 1'b0, 32'h2000_0008);
        idle(8, 1'b1);
        rd(A_STATUS, 1'b0, 32'h1000_0000);

        // Done register freezes the counter and captures only the first write
        wr(A_DONE, 32'h1A5, 1'b0);
        rd(A_DONE, 1'b0, 32'h1A5);
        rdModel(A_CYCLES, 1'b0);
        idle(3, 1'b0);
        rdModel(A_CYCLES, 1'b0);
        wr(A_DONE, 32'h07, 1'b0);
        rd(A_DONE, 1'b0, 32'h1A5);

        // Mid-operation reset with queued data; the store in the reset cycle is dropped
        for (int i = 0; i < 3; i++) wr(A_TX, 32'hA0 + 32'(i), 1'b0);
        reset = 1'b1;
        wr(32'h0000_0040, 32'hCAFE_F00D, 1'b0);
        reset = 1'b0;
        rd(A_CYCLES, 1'b0, 32'h0);
        rdModel(32'h0000_0040, 1'b0);
        rd(A_DONE, 1'b0, 32'h0);
        rd(A_STATUS, 1'b0, 32'h1000_0000);

        // Random bus traffic
        for (int n = 0; n < 3000; n++) begin
            r   = $urandom_range(0, 99);
            rdy = ($urandom_range(0, 9) < 4);
            a   = 32'($urandom_range(0, 2047));
            d   = $urandom;
            if (r < 20)      wr(a, d, rdy);
            else if (r < 40) rdModel(a, rdy);
            else if (r < 55) wr(A_TX, d, rdy);
            else if (r < 65) rdModel(A_STATUS, rdy);
            else if (r < 70) wr(A_STATUS, d, rdy);
            else if (r < 75) rdModel(A_CYCLES, rdy);
            else if (r < 78) rdModel(A_DONE, rdy);
            else if (r < 79) wr(A_DONE, d, rdy);
            else if (r < 80) begin
                reset = 1'b1;
                wr(a, d, rdy);
                reset = 1'b0;
            end
            else if (r < 85) rdModel({16'hFFFF, 16'($urandom_range(0, 63))}, rdy);
            else if (r < 88) wr({16'hFFFF, 16'($urandom_range(0, 63))}, d, rdy);
            else             idle(1, rdy);
        end

        idle(FD + 2, 1'b1);
        rdPending = 1'b0;
        checkOutput("read_scoreboard_drained", 32'(rdExpQ.size()), 32'h0);
        checkOutput("fifo_scoreboard_drained", 32'(expQ.size()), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
- Memory-side responder for the multi-cycle MIPS core's unified instruction/data bus (adr, writedata, memwrite in; readdata out).
- Holds a word-addressed RAM plus a small MMIO window:
  - free-running cycle counter
  - program-done/exit-code register
  - 8-entry output FIFO drained by a valid/ready port
  - status register
- Sits beside the core in the system top and serves every fetch, load and store.

Parameters:
- DEPTH, 256, RAM size in 32-bit words; power of two.
- INIT_FILE, "memfile.dat", hex image loaded when MEM_INIT_EN is defined.
- FIFO_DEPTH, 8, output FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- adr  input  32  byte address from core.
- writedata  input  32  store data from core.
- memwrite  input  1  store strobe, sampled at clk rising edge.
- readdata  output  32  combinational read data for adr.
- out_data  output  32  FIFO head word.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head when out_valid is high.
- done  output  1  program has written the done register.
- exit_code  output  8  value written with done.

Behaviour:
- Address decode:
  - MMIO when adr[31:16] == 16'hFFFF; otherwise RAM.
  - adr[1:0] ignored everywhere.
  - RAM index = adr[log2(DEPTH)+1:2]; out-of-range addresses alias modulo DEPTH.
- RAM:
  - Read: readdata = ram[index] combinationally (zero-latency; core captures it on the next edge).
  - Write: on clk edge when memwrite && !MMIO; new value visible to combinational read after that edge.
  - Contents not affected by reset.
- MMIO map (offset = adr[15:0]):
  - 0x0000 CYCLES (R):
    - 32-bit counter; reset to 0.
    - +1 every cycle while done==0; frozen once done==1.
    - Wraps 0xFFFFFFFF -> 0.
    - Writes ignored.
  - 0x0004 DONE (W):
    - First write sets done=1 and exit_code=writedata[7:0].
    - Later writes ignored until reset.
    - Reads return {23'b0, done, exit_code}.
  - 0x0008 TXDATA (W):
    - A write pushes writedata into the FIFO.
    - Reads return 0.
  - 0x000C STATUS (R/W):
    - Read returns {overflow[31], done[30], full[29], empty[28], 24'b0, count[3:0]}; count saturates in 4 bits for FIFO_DEPTH > 15.
    - A write with writedata[31]=1 clears overflow.
  - Any other MMIO offset: reads 0, writes ignored.
- FIFO:
  - Circular buffer with read pointer, write pointer and count.
  - out_valid = (count != 0); out_data = mem[rd_ptr], valid only when out_valid.
  - Pop: when out_valid && out_ready, at clk edge.
  - Push: when a TXDATA write occurs and (count < FIFO_DEPTH or a pop occurs the same cycle).
  - Overflow: a push attempted while full with no same-cycle pop drops the data and sets overflow (sticky).
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.
  - Overflow-clear write and a same-cycle overflow event: the set wins.
- Reset (synchronous, active-high), mid-operation included:
  - Cycle counter = 0; done = 0; exit_code = 0.
  - FIFO pointers and count = 0, so out_valid = 0; overflow = 0.
  - Any store in the reset cycle is ignored: no RAM write, no push, no DONE capture.
  - readdata stays combinational from adr during reset.
- No stalls: every access completes in the cycle presented.

Optional Feature:
- MEM_INIT_EN:
  - Defined: RAM preloaded at elaboration from INIT_FILE via $readmemh.
  - Undefined: RAM initialised to all zeros at elaboration; the program must be written by the bench through the bus.
- Decode and MMIO behaviour identical either way.

Test Plan:
- RAM write/read: store 0xDEADBEEF at adr 0x00000010, then set adr 0x00000012 -> readdata 0xDEADBEEF; store to adr 0x00000410 with DEPTH=256 aliases word 4, so 0x00000010 reads the new value.
- Cycle counter and done: release reset, idle 10 cycles -> CYCLES reads 10; write 0x1A5 to 0xFFFF0004 -> done=1, exit_code=0xA5, CYCLES frozen; a second write of 0x07 leaves exit_code=0xA5.
- FIFO fill/drain: out_ready=0, push 1..8 -> STATUS = 0x20000008 (full, count 8); ninth push dropped and overflow set -> STATUS = 0xA0000008; out_ready=1 -> out_data 1..8 on consecutive cycles, then out_valid=0.
- Full FIFO simultaneous push and pop: 8 entries, out_ready=1, push 0x99 in the same cycle -> no overflow, count stays 8, 0x99 emerges last.
- Overflow clear and reset: with overflow set, write 0x80000000 to STATUS -> bit 31 clears; assert reset for 1 cycle with 3 entries queued and done=1 -> out_valid=0, done=0, CYCLES=0.
- Unmapped MMIO: read 0xFFFF0020 -> 0; write 0xFFFF0020 -> RAM and registers unchanged.
